// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared types and elaboration helpers for the bitonic merge stream
package bitonic_pkg;

  typedef enum logic {
    DIR_DESC = 1'b0,
    DIR_ASC  = 1'b1
  } dir_e;

  // Distance between the two elements of a compare-exchange pair in stage s.
  function automatic int partner_dist(input int s, input int depth);
    return depth >> (s + 1);
  endfunction

  // Number of merge stages, log2(depth), never less than one.
  function automatic int stage_count(input int depth);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) n = i + 1;
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/bitonic_merge_stream_cas_stage.sv
// rtl/bitonic_merge_stream_cas_stage.sv - one registered compare-exchange layer (tags kept when BITONIC_MERGE_TAG_EN)
module bm_cas_stage
  import bitonic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             dir_in,
  input  logic [WIDTH-1:0] keys_in [DEPTH-1:0],
  input  logic [TAG_W-1:0] tags_in [DEPTH-1:0],
  output logic             ready_out,
  input  logic             ready_in,
  output logic             valid_q,
  output logic             dir_q,
  output logic [WIDTH-1:0] keys_q  [DEPTH-1:0],
  output logic [TAG_W-1:0] tags_q  [DEPTH-1:0]
);

  localparam int DIST = partner_dist(STAGE, DEPTH);

  dir_e             dir_c;
  logic [WIDTH-1:0] nk [DEPTH-1:0];
`ifdef BITONIC_MERGE_TAG_EN
  logic [TAG_W-1:0] nt [DEPTH-1:0];
`endif

  assign dir_c     = dir_e'(dir_in);
  assign ready_out = !valid_q || ready_in;

  // Each low element (bit for this stage clear) owns the pair with its partner DIST above it.
  for (genvar i = 0; i < DEPTH; i++) begin : g_pair
    if ((i & DIST) == 0) begin : g_lo
      logic swap;
      assign swap = (dir_c == DIR_ASC) ? (keys_in[i] > keys_in[i+DIST])
                                       : (keys_in[i] < keys_in[i+DIST]);
      assign nk[i]      = swap ? keys_in[i+DIST] : keys_in[i];
      assign nk[i+DIST] = swap ? keys_in[i]      : keys_in[i+DIST];
`ifdef BITONIC_MERGE_TAG_EN
      assign nt[i]      = swap ? tags_in[i+DIST] : tags_in[i];
      assign nt[i+DIST] = swap ? tags_in[i]      : tags_in[i+DIST];
`endif
    end
  end

  // Load when empty or draining; data only moves with a valid beat so idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      keys_q  <= '{default: '0};
    end else if (ready_out) begin
      valid_q <= valid_in;
      if (valid_in) begin
        dir_q  <= dir_c;
        keys_q <= nk;
      end
    end
  end

`ifdef BITONIC_MERGE_TAG_EN
  // Tags follow the same load rule as the keys they travel with.
  always_ff @(posedge clk) begin
    if (rst) begin
      tags_q <= '{default: '0};
    end else if (ready_out && valid_in) begin
      tags_q <= nt;
    end
  end
`else
  logic [DEPTH-1:0] tags_unused;
  for (genvar i = 0; i < DEPTH; i++) begin : g_notag
    assign tags_q[i]      = '0;
    assign tags_unused[i] = ^tags_in[i];
  end
`endif

endmodule

// File: rtl/bitonic_merge_stream.sv
// rtl/bitonic_merge_stream.sv - streaming bitonic merger top; optional tags via BITONIC_MERGE_TAG_EN
module bitonic_merge_stream
  import bitonic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int L     = stage_count(DEPTH),
  localparam int OCC_W = $clog2(L + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dir,
  input  logic [WIDTH-1:0] in_keys   [DEPTH-1:0],
  input  logic [TAG_W-1:0] in_tags   [DEPTH-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_dir,
  output logic [WIDTH-1:0] out_keys  [DEPTH-1:0],
  output logic [TAG_W-1:0] out_tags  [DEPTH-1:0],
  output logic [OCC_W-1:0] occupancy
);

  // Index s is the input of stage s; index L is the pipeline output.
  logic             sv  [0:L];
  logic             sd  [0:L];
  logic             rdy [0:L];
  logic [WIDTH-1:0] sk  [0:L][DEPTH-1:0];
  logic [TAG_W-1:0] st  [0:L][DEPTH-1:0];

  logic in_hs;
  logic out_hs;

  assign sv[0]  = in_valid;
  assign sd[0]  = in_dir;
  assign sk[0]  = in_keys;
  assign st[0]  = in_tags;
  assign rdy[L] = out_ready;

  assign in_ready  = rdy[0];
  assign out_valid = sv[L];
  assign out_dir   = sd[L];
  assign out_keys  = sk[L];
  assign out_tags  = st[L];

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  for (genvar s = 0; s < L; s++) begin : g_stage
    bm_cas_stage #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STAGE (s)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (sv[s]),
      .dir_in    (sd[s]),
      .keys_in   (sk[s]),
      .tags_in   (st[s]),
      .ready_out (rdy[s]),
      .ready_in  (rdy[s+1]),
      .valid_q   (sv[s+1]),
      .dir_q     (sd[s+1]),
      .keys_q    (sk[s+1]),
      .tags_q    (st[s+1])
    );
  end

  // Beats in flight: count up on accept, down on emit; both together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({in_hs, out_hs})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_merge_stream.sv
// tb/tb_bitonic_merge_stream.sv - scoreboard bench for bitonic_merge_stream (DEPTH=8, WIDTH=8)
module tb_bitonic_merge_stream;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam logic [31:0] TAG_SEQ = 32'h7654_3210;

  typedef struct packed {
    logic        dir;
    logic [63:0] keys;
    logic [31:0] tags;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_dir;
  logic [WIDTH-1:0] in_keys  [DEPTH-1:0];
  logic [TAG_W-1:0] in_tags  [DEPTH-1:0];
  logic             out_valid;
  logic             out_ready;
  logic             out_dir;
  logic [WIDTH-1:0] out_keys [DEPTH-1:0];
  logic [TAG_W-1:0] out_tags [DEPTH-1:0];
  logic [1:0]       occupancy;

  beat_t       sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          acc_cyc = 0;
  int          out_cyc = 0;
  int          prev_out_cyc = 0;
  int          n0;
  logic        acc;
  logic        cur_dir;
  logic [63:0] cur_keys;
  logic [31:0] cur_tags;

  always #5 clk = ~clk;

  bitonic_merge_stream #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_keys   (in_keys),
    .in_tags   (in_tags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_keys  (out_keys),
    .out_tags  (out_tags),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] kv(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [63:0] pack_keys(input logic [7:0] a [7:0]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [31:0] pack_tags(input logic [3:0] a [7:0]);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = a[i];
    return r;
  endfunction

  // Expected result: stable sort in the requested direction, tags carried with keys.
  function automatic beat_t model(input logic dir, input logic [63:0] keys, input logic [31:0] tags);
    logic [7:0] k [8];
    logic [3:0] t [8];
    logic [7:0] tk;
    logic [3:0] tt;
    beat_t      b;
    for (int i = 0; i < 8; i++) begin
      k[i] = keys[8*i +: 8];
      t[i] = tags[4*i +: 4];
    end
    for (int p = 0; p < 7; p++) begin
      for (int j = 0; j < 7; j++) begin
        if (dir ? (k[j+1] < k[j]) : (k[j+1] > k[j])) begin
          tk = k[j]; k[j] = k[j+1]; k[j+1] = tk;
          tt = t[j]; t[j] = t[j+1]; t[j+1] = tt;
        end
      end
    end
    b.dir = dir;
    for (int i = 0; i < 8; i++) begin
      b.keys[8*i +: 8] = k[i];
`ifdef BITONIC_MERGE_TAG_EN
      b.tags[4*i +: 4] = t[i];
`else
      b.tags[4*i +: 4] = 4'd0;
`endif
    end
    return b;
  endfunction

  function automatic logic [63:0] rnd_bitonic();
    logic [7:0] a [8];
    for (int j = 0; j < 8; j++) a[j] = 8'(j * 30 + $urandom_range(0, 29));
    return {a[1], a[3], a[5], a[7], a[6], a[4], a[2], a[0]};
  endfunction

  task automatic drive(input logic dir, input logic [63:0] keys, input logic [31:0] tags);
    cur_dir  = dir;
    cur_keys = keys;
    cur_tags = tags;
    in_dir   = dir;
    for (int i = 0; i < 8; i++) begin
      in_keys[i] = keys[8*i +: 8];
      in_tags[i] = tags[4*i +: 4];
    end
    in_valid = 1'b1;
  endtask

  // One clock: observe handshakes before the edge, then advance past it.
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      sb.push_back(model(cur_dir, cur_keys, cur_tags));
      acc_cyc = cyc;
    end
    if (out_valid === 1'b1 && !rst) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_out: observed=out_valid expected=no_beat_pending");
      end
      if (sb.size() != 0) begin
        chk("out_keys", pack_keys(out_keys), sb[0].keys);
        chk("out_tags", pack_tags(out_tags), sb[0].tags);
        chk("out_dir", out_dir, sb[0].dir);
      end
      if (out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        n_out++;
        prev_out_cyc = out_cyc;
        out_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_wait(input logic dir, input logic [63:0] keys, input logic [31:0] tags,
                           input logic rnd_ready);
    logic done;
    done = 1'b0;
    drive(dir, keys, tags);
    for (int i = 0; i < 40 && !done; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      done = acc;
    end
    chk("accept_timeout", done, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < bound && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 32'd0);
    in_valid  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_dir", out_dir, 1'b0);
    chk("rst_out_keys", pack_keys(out_keys), 64'd0);
    chk("rst_out_tags", pack_tags(out_tags), 32'd0);

    // Ascending merge with latency and single-cycle output
    send_wait(1'b1, kv(1, 3, 5, 7, 8, 6, 4, 2), TAG_SEQ, 1'b0);
    step();
    chk("asc_not_early", out_valid, 1'b0);
    step();
    chk("asc_valid", out_valid, 1'b1);
    chk("asc_literal", pack_keys(out_keys), kv(1, 2, 3, 4, 5, 6, 7, 8));
    step();
    chk("asc_latency", out_cyc - acc_cyc, 3);
    chk("asc_one_cycle", out_valid, 1'b0);

    // Mixed directions back-to-back
    send_wait(1'b0, kv(1, 3, 5, 7, 8, 6, 4, 2), TAG_SEQ, 1'b0);
    send_wait(1'b1, kv(2, 4, 6, 8, 7, 5, 3, 1), TAG_SEQ, 1'b0);
    step();
    chk("desc_literal", pack_keys(out_keys), kv(8, 7, 6, 5, 4, 3, 2, 1));
    drain(10);
    chk("mixed_consecutive", out_cyc - prev_out_cyc, 1);

    // Backpressure: three accepted, then stall
    n0 = n_out;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++)
      send_wait(1'(b % 2), kv(10+b, 20+b, 30+b, 40+b, 35+b, 25+b, 15+b, 5+b), TAG_SEQ, 1'b0);
    drive(1'b1, kv(13, 23, 33, 43, 38, 28, 18, 8), TAG_SEQ);
    step();
    step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_occupancy", occupancy, 2'd3);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_hold_keys", pack_keys(out_keys), sb[0].keys);
    step();
    chk("bp_hold_keys2", pack_keys(out_keys), sb[0].keys);
    chk("bp_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    send_wait(1'b1, kv(13, 23, 33, 43, 38, 28, 18, 8), TAG_SEQ, 1'b0);
    send_wait(1'b0, kv(14, 24, 34, 44, 39, 29, 19, 9), TAG_SEQ, 1'b0);
    drain(20);
    chk("bp_count", n_out - n0, 5);

    // Bubble collapse under stall
    n0 = n_out;
    out_ready = 1'b0;
    send_wait(1'b1, kv(50, 60, 70, 80, 75, 65, 55, 45), TAG_SEQ, 1'b0);
    step();
    step();
    send_wait(1'b0, kv(3, 9, 12, 99, 90, 40, 7, 1), TAG_SEQ, 1'b0);
    step();
    chk("bub_occupancy", occupancy, 2'd2);
    chk("bub_out_valid", out_valid, 1'b1);
    chk("bub_in_ready", in_ready, 1'b1);
    chk("bub_head", pack_keys(out_keys), kv(45, 50, 55, 60, 65, 70, 75, 80));
    chk("bub_pending", sb.size(), 2);
    step();
    chk("bub_occupancy_hold", occupancy, 2'd2);
    drain(10);
    chk("bub_count", n_out - n0, 2);

    // Ties: equal keys never swap, tags stay in place
    send_wait(1'b1, kv(5, 5, 5, 5, 5, 5, 5, 5), TAG_SEQ, 1'b0);
    send_wait(1'b0, kv(5, 5, 5, 5, 5, 5, 5, 5), TAG_SEQ, 1'b0);
    step();
`ifdef BITONIC_MERGE_TAG_EN
    chk("tie_tags", pack_tags(out_tags), TAG_SEQ);
`else
    chk("tie_tags", pack_tags(out_tags), 32'd0);
`endif
    drain(10);

    // Reset mid-flight drops in-flight beats
    n0 = n_out;
    out_ready = 1'b1;
    send_wait(1'b1, kv(1, 3, 5, 7, 8, 6, 4, 2), TAG_SEQ, 1'b0);
    send_wait(1'b0, kv(2, 4, 6, 8, 7, 5, 3, 1), TAG_SEQ, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_occupancy", occupancy, 2'd0);
    chk("mrst_in_ready", in_ready, 1'b1);
    repeat (5) step();
    chk("mrst_no_output", n_out - n0, 0);

    // Random bitonic beats under random downstream readiness
    n0 = n_out;
    for (int b = 0; b < 16; b++)
      send_wait(1'($urandom_range(0, 1)), rnd_bitonic(), TAG_SEQ, 1'b1);
    drain(60);
    chk("rnd_count", n_out - n0, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
